aud_mode_ctrl: RTL and testbench
================================

Name: aud_mode_ctrl

Overview:
- Central mode controller for the lab3 audio record/playback system.
- Converts debounced push-key levels into one-cycle start/pause/stop commands for the recorder and the DSP/player, and owns the SRAM write-select.
- Latches the playback speed and interpolation mode, and keeps an elapsed-seconds counter for the seven-segment display.
- Sits in the top level between the I2C initializer's finish flag and the AudRecorder / AudDSP / AudPlayer instances.

Parameters:
- CLK_FREQ, 12000000: i_clk cycles per second; sets the timer prescaler.
- TIME_W, 6: width of o_time_sec.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous active-low reset
- i_key_0  in  1  debounced key 0 level, 1 = pressed: record / record-pause
- i_key_1  in  1  debounced key 1 level, 1 = pressed: play / play-pause
- i_key_2  in  1  debounced key 2 level, 1 = pressed: stop
- i_mode  in  2  00 normal, 01 fast, 10 slow constant interpolation, 11 slow linear interpolation
- i_speed  in  3  speed factor 1..7; 0 is treated as 1
- i_init_finished  in  1  WM8731 I2C init complete (level)
- i_rec_full  in  1  recorder reached its last SRAM address
- i_play_done  in  1  player reached the final recorded address
- o_state  out  3  current state encoding
- o_rec_start, o_rec_pause, o_rec_stop  out  1 each  one-cycle recorder command pulses
- o_play_start, o_play_pause, o_play_stop  out  1 each  one-cycle player command pulses
- o_play_en  out  1  AudPlayer enable level
- o_sram_we_sel  out  1  1 = recorder drives SRAM address/data and WE_N low
- o_fast, o_slow_0, o_slow_1  out  1 each  latched playback mode, at most one high
- o_speed  out  3  latched speed factor, range 1..7
- o_time_sec  out  TIME_W  elapsed record/play seconds

Behaviour:
- Reset: synchronous; when i_rst_n is low at a rising i_clk edge, the block enters S_INIT.
  - All outputs are 0, except o_speed = 1.
  - Timer and prescaler are cleared.
  - Key history registers are set to 1, so a key held through reset produces no edge.
  - Reset mid-operation aborts the current operation with no stop pulse.
- Key event: key history is registered each cycle; an event is i_key_n = 1 while its history = 0. Only events are acted on, never levels.
- Latency: for an event or status input sampled at edge N, the new state and the command pulse are registered at edge N. Both are visible during cycle N+1, and each pulse lasts exactly 1 cycle.
- States: S_INIT = 0, S_IDLE = 1, S_RECD = 2, S_RECD_PAUSE = 3, S_PLAY = 4, S_PLAY_PAUSE = 5. Encodings 6 and 7 recover to S_IDLE.
- Transitions (same-cycle priority is stop > key0 > key1; events irrelevant to the current state are ignored):
  - S_INIT: i_init_finished -> S_IDLE.
  - S_IDLE: key0 -> S_RECD with o_rec_start and timer clear. key1 -> S_PLAY with o_play_start, timer clear and mode latch. key2 is ignored.
  - S_RECD: key2 or i_rec_full -> S_IDLE with a single o_rec_stop; this stop wins over a simultaneous key0. Otherwise key0 -> S_RECD_PAUSE with o_rec_pause.
  - S_RECD_PAUSE: key2 -> S_IDLE with o_rec_stop. key0 -> S_RECD with o_rec_start. i_rec_full is ignored.
  - S_PLAY: key2 or i_play_done -> S_IDLE with a single o_play_stop. key1 -> S_PLAY_PAUSE with o_play_pause.
  - S_PLAY_PAUSE: key2 -> S_IDLE with o_play_stop. key1 -> S_PLAY with o_play_start and mode re-latch.
- Mode latch:
  - i_mode and i_speed are sampled only on entry to S_PLAY.
  - Normal mode forces o_speed = 1 with all three mode flags at 0.
  - i_speed = 0 is mapped to 1.
  - Flags and o_speed hold through S_PLAY_PAUSE. On entry to S_IDLE the flags clear and o_speed returns to 1.
- Levels:
  - o_play_en = 1 only in S_PLAY.
  - o_sram_we_sel = 1 only in S_RECD.
  - o_state mirrors the state register.
- Timer:
  - The prescaler counts 0..CLK_FREQ-1 only in S_RECD and S_PLAY, and holds in the pause states.
  - At wrap, o_time_sec increments, saturating at 2^TIME_W-1.
  - The timer clears on S_IDLE -> S_RECD and on S_IDLE -> S_PLAY, and holds its value in S_IDLE for display.

Decomposition:
- Package aud_ctrl_pkg holds:
  - state_t enum
  - mode_t enum (MODE_NORMAL, MODE_FAST, MODE_SLOW0, MODE_SLOW1)
  - default CLK_FREQ
  - speed min/max constants
- One sub-module, key_edge: a parameterised-width rising-edge detector with reset-to-1 history, instantiated once for the 3 keys.

Test Plan:
- Reset with i_key_0 held high, then release reset with i_init_finished = 1 -> state 0 then 1; no o_rec_start is generated.
- CLK_FREQ = 10. Key0 pulse in S_IDLE, wait 35 cycles, key0 pulse, wait 20 cycles -> o_rec_start once, o_sram_we_sel high only while in S_RECD, o_time_sec = 3 held during pause; then o_rec_pause once.
- i_mode = 01, i_speed = 0, key1 -> o_fast = 1, o_speed = 1, o_play_en = 1. Change i_mode to 11 mid-play -> outputs unchanged. Key1 to pause, set i_mode = 11, i_speed = 5, key1 to resume -> o_slow_1 = 1, o_speed = 5.
- In S_RECD, assert i_rec_full and key0 in the same cycle -> exactly one o_rec_stop, state 1, no o_rec_pause.
- In S_PLAY, assert key2 and i_play_done together -> single o_play_stop, o_play_en = 0 next cycle, mode flags cleared, o_speed = 1.
- Run with timer at 62, continue for 3 s in S_PLAY -> saturates at 63. Pull i_rst_n low for 1 cycle mid-play -> all outputs 0, o_speed = 1, state 0 on the next cycle.

Source files
------------

// File: rtl/aud_mode_ctrl_pkg.sv
// Shared types and constants for the audio mode controller.
package aud_ctrl_pkg;

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_IDLE       = 3'd1,
        S_RECD       = 3'd2,
        S_RECD_PAUSE = 3'd3,
        S_PLAY       = 3'd4,
        S_PLAY_PAUSE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_FAST   = 2'd1,
        MODE_SLOW0  = 2'd2,
        MODE_SLOW1  = 2'd3
    } mode_t;

    typedef struct packed {
        logic rec_start;
        logic rec_pause;
        logic rec_stop;
        logic play_start;
        logic play_pause;
        logic play_stop;
    } cmd_t;

    typedef struct packed {
        logic       fast;
        logic       slow_0;
        logic       slow_1;
        logic [2:0] speed;
    } play_cfg_t;

    localparam int         DEF_CLK_FREQ = 12_000_000;
    localparam logic [2:0] SPEED_MIN    = 3'd1;
    localparam logic [2:0] SPEED_MAX    = 3'd7;

    localparam play_cfg_t  CFG_IDLE     = {3'b000, SPEED_MIN};

    // Normal playback ignores the speed input entirely; speed 0 reads as 1.
    function automatic play_cfg_t decode_cfg(input mode_t mode, input logic [2:0] speed);
        play_cfg_t c;
        c = CFG_IDLE;
        case (mode)
            MODE_FAST:  c.fast   = 1'b1;
            MODE_SLOW0: c.slow_0 = 1'b1;
            MODE_SLOW1: c.slow_1 = 1'b1;
            default:    ;
        endcase
        if (mode != MODE_NORMAL) begin
            c.speed = (speed < SPEED_MIN) ? SPEED_MIN : speed;
        end
        return c;
    endfunction

endpackage

// File: rtl/aud_mode_ctrl_if.sv
// Key, status and command bundle between the mode controller and the audio top level.
interface aud_mode_ctrl_if
    import aud_ctrl_pkg::*;
#(
    parameter int TIME_W = 6
);
    logic              i_key_0;
    logic              i_key_1;
    logic              i_key_2;
    logic [1:0]        i_mode;
    logic [2:0]        i_speed;
    logic              i_init_finished;
    logic              i_rec_full;
    logic              i_play_done;

    state_t            o_state;
    logic              o_rec_start;
    logic              o_rec_pause;
    logic              o_rec_stop;
    logic              o_play_start;
    logic              o_play_pause;
    logic              o_play_stop;
    logic              o_play_en;
    logic              o_sram_we_sel;
    logic              o_fast;
    logic              o_slow_0;
    logic              o_slow_1;
    logic [2:0]        o_speed;
    logic [TIME_W-1:0] o_time_sec;

    modport slave (
        input  i_key_0, i_key_1, i_key_2, i_mode, i_speed,
               i_init_finished, i_rec_full, i_play_done,
        output o_state, o_rec_start, o_rec_pause, o_rec_stop,
               o_play_start, o_play_pause, o_play_stop, o_play_en,
               o_sram_we_sel, o_fast, o_slow_0, o_slow_1, o_speed, o_time_sec
    );

    modport master (
        output i_key_0, i_key_1, i_key_2, i_mode, i_speed,
               i_init_finished, i_rec_full, i_play_done,
        input  o_state, o_rec_start, o_rec_pause, o_rec_stop,
               o_play_start, o_play_pause, o_play_stop, o_play_en,
               o_sram_we_sel, o_fast, o_slow_0, o_slow_1, o_speed, o_time_sec
    );

endinterface

// File: rtl/aud_mode_ctrl_key_edge.sv
// Rising-edge detector for debounced key levels; history resets high so a key
// held through reset does not fire.
module key_edge #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] lvl,
    output logic [W-1:0] rise
);
    logic [W-1:0] hist;

    always_ff @(posedge clk) begin
        if (!rst_n) hist <= '1;
        else        hist <= lvl;
    end

    assign rise = lvl & ~hist;

endmodule

// File: rtl/aud_mode_ctrl.sv
// Audio mode controller: key edges -> one-cycle recorder/player commands,
// playback mode latch and elapsed-seconds timer.
//   state        | meaning
//   S_INIT       | waiting for codec I2C init
//   S_IDLE       | stopped, timer shows last run
//   S_RECD       | recording, recorder owns SRAM
//   S_RECD_PAUSE | recording paused
//   S_PLAY       | playing, player enabled
//   S_PLAY_PAUSE | playback paused, mode held
module aud_mode_ctrl
    import aud_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int TIME_W   = 6
) (
    input logic            i_clk,
    input logic            i_rst_n,
    aud_mode_ctrl_if.slave bus
);
    localparam int                 PRESC_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ - 1);
    localparam logic [TIME_W-1:0]  TIME_MAX   = '1;

    state_t             state;
    cmd_t               cmd;
    play_cfg_t          cfg;
    play_cfg_t          cfg_new;
    logic               play_en;
    logic               sram_we_sel;
    logic [PRESC_W-1:0] presc;
    logic [TIME_W-1:0]  time_sec;
    logic [2:0]         key_ev;
    logic               ev_rec;
    logic               ev_play;
    logic               ev_stop;

    key_edge #(.W(3)) u_key_edge (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .lvl   ({bus.i_key_2, bus.i_key_1, bus.i_key_0}),
        .rise  (key_ev)
    );

    assign ev_rec  = key_ev[0];
    assign ev_play = key_ev[1];
    assign ev_stop = key_ev[2];
    assign cfg_new = decode_cfg(mode_t'(bus.i_mode), bus.i_speed);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= S_INIT;
            cmd         <= '0;
            cfg         <= CFG_IDLE;
            play_en     <= 1'b0;
            sram_we_sel <= 1'b0;
            presc       <= '0;
            time_sec    <= '0;
        end else begin
            cmd <= '0;
            // Prescaler runs only while actively recording or playing.
            if (state == S_RECD || state == S_PLAY) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    if (time_sec != TIME_MAX) time_sec <= time_sec + TIME_W'(1);
                end else begin
                    presc <= presc + PRESC_W'(1);
                end
            end
            case (state)
                S_INIT: if (bus.i_init_finished) state <= S_IDLE;
                S_IDLE: begin
                    if (ev_rec) begin
                        state         <= S_RECD;
                        cmd.rec_start <= 1'b1;
                        sram_we_sel   <= 1'b1;
                        presc         <= '0;
                        time_sec      <= '0;
                    end else if (ev_play) begin
                        state          <= S_PLAY;
                        cmd.play_start <= 1'b1;
                        play_en        <= 1'b1;
                        cfg            <= cfg_new;
                        presc          <= '0;
                        time_sec       <= '0;
                    end
                end
                S_RECD: begin
                    if (ev_stop || bus.i_rec_full) begin
                        state        <= S_IDLE;
                        cmd.rec_stop <= 1'b1;
                        sram_we_sel  <= 1'b0;
                    end else if (ev_rec) begin
                        state         <= S_RECD_PAUSE;
                        cmd.rec_pause <= 1'b1;
                        sram_we_sel   <= 1'b0;
                    end
                end
                S_RECD_PAUSE: begin
                    if (ev_stop) begin
                        state        <= S_IDLE;
                        cmd.rec_stop <= 1'b1;
                    end else if (ev_rec) begin
                        state         <= S_RECD;
                        cmd.rec_start <= 1'b1;
                        sram_we_sel   <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (ev_stop || bus.i_play_done) begin
                        state         <= S_IDLE;
                        cmd.play_stop <= 1'b1;
                        play_en       <= 1'b0;
                        cfg           <= CFG_IDLE;
                    end else if (ev_play) begin
                        state          <= S_PLAY_PAUSE;
                        cmd.play_pause <= 1'b1;
                        play_en        <= 1'b0;
                    end
                end
                S_PLAY_PAUSE: begin
                    if (ev_stop) begin
                        state         <= S_IDLE;
                        cmd.play_stop <= 1'b1;
                        cfg           <= CFG_IDLE;
                    end else if (ev_play) begin
                        state          <= S_PLAY;
                        cmd.play_start <= 1'b1;
                        play_en        <= 1'b1;
                        cfg            <= cfg_new;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    play_en     <= 1'b0;
                    sram_we_sel <= 1'b0;
                    cfg         <= CFG_IDLE;
                end
            endcase
        end
    end

    assign bus.o_state       = state;
    assign bus.o_rec_start   = cmd.rec_start;
    assign bus.o_rec_pause   = cmd.rec_pause;
    assign bus.o_rec_stop    = cmd.rec_stop;
    assign bus.o_play_start  = cmd.play_start;
    assign bus.o_play_pause  = cmd.play_pause;
    assign bus.o_play_stop   = cmd.play_stop;
    assign bus.o_play_en     = play_en;
    assign bus.o_sram_we_sel = sram_we_sel;
    assign bus.o_fast        = cfg.fast;
    assign bus.o_slow_0      = cfg.slow_0;
    assign bus.o_slow_1      = cfg.slow_1;
    assign bus.o_speed       = cfg.speed;
    assign bus.o_time_sec    = time_sec;

endmodule

// File: tb/tb_aud_mode_ctrl.sv
// Bench for aud_mode_ctrl: directed scenarios plus randomized keys/status
// checked every cycle against a behavioural model.
module tb_aud_mode_ctrl;
    localparam int CLK_FREQ = 10;
    localparam int TIME_W   = 6;
    localparam int TMAX     = (1 << TIME_W) - 1;
    localparam logic [22:0] RESET_VEC = {3'd0, 6'd0, 2'd0, 3'd0, 3'd1, 6'd0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aud_mode_ctrl_if #(.TIME_W(TIME_W)) bus ();

    aud_mode_ctrl #(.CLK_FREQ(CLK_FREQ), .TIME_W(TIME_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: states by their numeric code, timer as total counted cycles.
    int       m_st;
    int       m_cnt;
    int       m_speed;
    bit [2:0] m_hist;
    bit       m_rs, m_rp, m_rx, m_ps, m_pp, m_px;
    bit       m_fast, m_slow0, m_slow1;

    task automatic m_latch();
        m_fast  = (bus.i_mode == 2'd1);
        m_slow0 = (bus.i_mode == 2'd2);
        m_slow1 = (bus.i_mode == 2'd3);
        if (bus.i_mode == 2'd0)      m_speed = 1;
        else if (bus.i_speed == 3'd0) m_speed = 1;
        else                          m_speed = int'(bus.i_speed);
    endtask

    always @(posedge clk) begin
        bit [2:0] lvl;
        bit [2:0] ev;
        lvl = {bus.i_key_2, bus.i_key_1, bus.i_key_0};
        if (!rst_n) begin
            m_st = 0; m_cnt = 0; m_hist = 3'b111; m_speed = 1;
            {m_rs, m_rp, m_rx, m_ps, m_pp, m_px} = '0;
            {m_fast, m_slow0, m_slow1} = '0;
        end else begin
            ev     = lvl & ~m_hist;
            m_hist = lvl;
            {m_rs, m_rp, m_rx, m_ps, m_pp, m_px} = '0;
            if ((m_st == 2 || m_st == 4) && m_cnt < 1000000) m_cnt++;
            case (m_st)
                0: if (bus.i_init_finished) m_st = 1;
                1: if (ev[0]) begin m_st = 2; m_rs = 1; m_cnt = 0; end
                   else if (ev[1]) begin m_st = 4; m_ps = 1; m_cnt = 0; m_latch(); end
                2: if (ev[2] || bus.i_rec_full) begin m_st = 1; m_rx = 1; end
                   else if (ev[0]) begin m_st = 3; m_rp = 1; end
                3: if (ev[2]) begin m_st = 1; m_rx = 1; end
                   else if (ev[0]) begin m_st = 2; m_rs = 1; end
                4: if (ev[2] || bus.i_play_done) begin m_st = 1; m_px = 1; end
                   else if (ev[1]) begin m_st = 5; m_pp = 1; end
                5: if (ev[2]) begin m_st = 1; m_px = 1; end
                   else if (ev[1]) begin m_st = 4; m_ps = 1; m_latch(); end
                default: m_st = 1;
            endcase
            if (m_st == 1) begin
                {m_fast, m_slow0, m_slow1} = '0;
                m_speed = 1;
            end
        end
    end

    function automatic logic [22:0] m_vec();
        int t;
        t = m_cnt / CLK_FREQ;
        if (t > TMAX) t = TMAX;
        return {3'(m_st), m_rs, m_rp, m_rx, m_ps, m_pp, m_px,
                (m_st == 4), (m_st == 2), m_fast, m_slow0, m_slow1,
                3'(m_speed), TIME_W'(t)};
    endfunction

    function automatic logic [22:0] dut_vec();
        return {bus.o_state, bus.o_rec_start, bus.o_rec_pause, bus.o_rec_stop,
                bus.o_play_start, bus.o_play_pause, bus.o_play_stop,
                bus.o_play_en, bus.o_sram_we_sel, bus.o_fast, bus.o_slow_0,
                bus.o_slow_1, bus.o_speed, bus.o_time_sec};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_key_0 = 1'b1;
        bus.i_init_finished = 1'b1;
        tick(); tick();
        n_cmp++;
        if (dut_vec() !== RESET_VEC) begin
            n_bad++; $display("FAIL reset_outputs got %h want %h", dut_vec(), RESET_VEC);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.o_state !== 3'd1) begin
            n_bad++; $display("FAIL reset_to_idle got %0d want 1", bus.o_state);
        end
        n_cmp++;
        if (bus.o_rec_start !== 1'b0) begin
            n_bad++; $display("FAIL held_key_no_start got %b want 0", bus.o_rec_start);
        end
        tick();
        n_cmp++;
        if ({bus.o_state, bus.o_rec_start} !== {3'd1, 1'b0}) begin
            n_bad++; $display("FAIL held_key_idle got %h want %h", {bus.o_state, bus.o_rec_start}, {3'd1, 1'b0});
        end
        bus.i_key_0 = 1'b0;
        tick();
    endtask

    task automatic test_record_timer();
        int n_start = 0;
        int n_pause = 0;
        bus.i_key_0 = 1'b1;
        tick();
        n_start += int'(bus.o_rec_start);
        n_cmp++;
        if ({bus.o_state, bus.o_sram_we_sel, bus.o_time_sec} !== {3'd2, 1'b1, 6'd0}) begin
            n_bad++; $display("FAIL rec_enter got %h want %h", {bus.o_state, bus.o_sram_we_sel, bus.o_time_sec}, {3'd2, 1'b1, 6'd0});
        end
        bus.i_key_0 = 1'b0;
        for (int i = 0; i < 34; i++) begin
            tick();
            n_start += int'(bus.o_rec_start);
            n_pause += int'(bus.o_rec_pause);
            n_cmp++;
            if ({bus.o_state, bus.o_sram_we_sel} !== {3'd2, 1'b1}) begin
                n_bad++; $display("FAIL rec_we_sel cyc%0d got %h want %h", i, {bus.o_state, bus.o_sram_we_sel}, {3'd2, 1'b1});
            end
        end
        bus.i_key_0 = 1'b1;
        tick();
        n_pause += int'(bus.o_rec_pause);
        n_cmp++;
        if ({bus.o_state, bus.o_sram_we_sel, bus.o_time_sec} !== {3'd3, 1'b0, 6'd3}) begin
            n_bad++; $display("FAIL rec_pause_enter got %h want %h", {bus.o_state, bus.o_sram_we_sel, bus.o_time_sec}, {3'd3, 1'b0, 6'd3});
        end
        bus.i_key_0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_start += int'(bus.o_rec_start);
            n_pause += int'(bus.o_rec_pause);
            n_cmp++;
            if ({bus.o_state, bus.o_sram_we_sel, bus.o_time_sec} !== {3'd3, 1'b0, 6'd3}) begin
                n_bad++; $display("FAIL rec_pause_hold cyc%0d got %h want %h", i, {bus.o_state, bus.o_sram_we_sel, bus.o_time_sec}, {3'd3, 1'b0, 6'd3});
            end
        end
        n_cmp++;
        if (n_start != 1 || n_pause != 1) begin
            n_bad++; $display("FAIL rec_pulse_counts got start=%0d pause=%0d want 1/1", n_start, n_pause);
        end
        bus.i_key_2 = 1'b1;
        tick();
        n_cmp++;
        if ({bus.o_state, bus.o_rec_stop} !== {3'd1, 1'b1}) begin
            n_bad++; $display("FAIL rec_pause_stop got %h want %h", {bus.o_state, bus.o_rec_stop}, {3'd1, 1'b1});
        end
        bus.i_key_2 = 1'b0;
        tick();
        n_cmp++;
        if ({bus.o_rec_stop, bus.o_time_sec} !== {1'b0, 6'd3}) begin
            n_bad++; $display("FAIL idle_time_hold got %h want %h", {bus.o_rec_stop, bus.o_time_sec}, {1'b0, 6'd3});
        end
    endtask

    task automatic test_play_mode();
        bus.i_mode = 2'b01; bus.i_speed = 3'd0; bus.i_key_1 = 1'b1;
        tick();
        n_cmp++;
        if ({bus.o_state, bus.o_play_start, bus.o_play_en, bus.o_fast, bus.o_slow_0, bus.o_slow_1, bus.o_speed}
            !== {3'd4, 1'b1, 1'b1, 3'b100, 3'd1}) begin
            n_bad++; $display("FAIL play_fast_latch got %h want %h",
                {bus.o_state, bus.o_play_start, bus.o_play_en, bus.o_fast, bus.o_slow_0, bus.o_slow_1, bus.o_speed},
                {3'd4, 1'b1, 1'b1, 3'b100, 3'd1});
        end
        bus.i_key_1 = 1'b0; bus.i_mode = 2'b11; bus.i_speed = 3'd6;
        repeat (5) tick();
        n_cmp++;
        if ({bus.o_state, bus.o_play_en, bus.o_fast, bus.o_slow_0, bus.o_slow_1, bus.o_speed}
            !== {3'd4, 1'b1, 3'b100, 3'd1}) begin
            n_bad++; $display("FAIL play_mode_stable got %h want %h",
                {bus.o_state, bus.o_play_en, bus.o_fast, bus.o_slow_0, bus.o_slow_1, bus.o_speed}, {3'd4, 1'b1, 3'b100, 3'd1});
        end
        bus.i_key_1 = 1'b1;
        tick();
        n_cmp++;
        if ({bus.o_state, bus.o_play_pause, bus.o_play_en, bus.o_fast, bus.o_speed} !== {3'd5, 1'b1, 1'b0, 1'b1, 3'd1}) begin
            n_bad++; $display("FAIL play_pause got %h want %h",
                {bus.o_state, bus.o_play_pause, bus.o_play_en, bus.o_fast, bus.o_speed}, {3'd5, 1'b1, 1'b0, 1'b1, 3'd1});
        end
        bus.i_key_1 = 1'b0; bus.i_mode = 2'b11; bus.i_speed = 3'd5;
        tick(); tick();
        bus.i_key_1 = 1'b1;
        tick();
        n_cmp++;
        if ({bus.o_state, bus.o_play_start, bus.o_play_en, bus.o_fast, bus.o_slow_0, bus.o_slow_1, bus.o_speed}
            !== {3'd4, 1'b1, 1'b1, 3'b001, 3'd5}) begin
            n_bad++; $display("FAIL play_relatch got %h want %h",
                {bus.o_state, bus.o_play_start, bus.o_play_en, bus.o_fast, bus.o_slow_0, bus.o_slow_1, bus.o_speed},
                {3'd4, 1'b1, 1'b1, 3'b001, 3'd5});
        end
        bus.i_key_1 = 1'b0;
        tick();
    endtask

    task automatic test_play_stop();
        bus.i_key_2 = 1'b1; bus.i_play_done = 1'b1;
        tick();
        n_cmp++;
        if ({bus.o_state, bus.o_play_stop, bus.o_play_en, bus.o_fast, bus.o_slow_0, bus.o_slow_1, bus.o_speed}
            !== {3'd1, 1'b1, 1'b0, 3'b000, 3'd1}) begin
            n_bad++; $display("FAIL play_stop got %h want %h",
                {bus.o_state, bus.o_play_stop, bus.o_play_en, bus.o_fast, bus.o_slow_0, bus.o_slow_1, bus.o_speed},
                {3'd1, 1'b1, 1'b0, 3'b000, 3'd1});
        end
        bus.i_key_2 = 1'b0; bus.i_play_done = 1'b0;
        tick();
        n_cmp++;
        if ({bus.o_state, bus.o_play_stop} !== {3'd1, 1'b0}) begin
            n_bad++; $display("FAIL play_stop_single got %h want %h", {bus.o_state, bus.o_play_stop}, {3'd1, 1'b0});
        end
    endtask

    task automatic test_rec_full_stop();
        bus.i_key_0 = 1'b1;
        tick();
        bus.i_key_0 = 1'b0;
        tick();
        n_cmp++;
        if (bus.o_state !== 3'd2) begin
            n_bad++; $display("FAIL rec_full_setup got %0d want 2", bus.o_state);
        end
        bus.i_key_0 = 1'b1; bus.i_rec_full = 1'b1;
        tick();
        n_cmp++;
        if ({bus.o_state, bus.o_rec_stop, bus.o_rec_pause, bus.o_sram_we_sel} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL rec_full_priority got %h want %h",
                {bus.o_state, bus.o_rec_stop, bus.o_rec_pause, bus.o_sram_we_sel}, {3'd1, 1'b1, 1'b0, 1'b0});
        end
        bus.i_key_0 = 1'b0; bus.i_rec_full = 1'b0;
        tick();
        n_cmp++;
        if ({bus.o_state, bus.o_rec_stop, bus.o_rec_pause} !== {3'd1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL rec_full_single got %h want %h", {bus.o_state, bus.o_rec_stop, bus.o_rec_pause}, {3'd1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_saturate_and_reset();
        bus.i_mode = 2'b00; bus.i_speed = 3'd3; bus.i_key_1 = 1'b1;
        tick();
        bus.i_key_1 = 1'b0;
        n_cmp++;
        if ({bus.o_state, bus.o_speed, bus.o_fast, bus.o_slow_0, bus.o_slow_1} !== {3'd4, 3'd1, 3'b000}) begin
            n_bad++; $display("FAIL normal_mode_latch got %h want %h",
                {bus.o_state, bus.o_speed, bus.o_fast, bus.o_slow_0, bus.o_slow_1}, {3'd4, 3'd1, 3'b000});
        end
        repeat (624) tick();
        n_cmp++;
        if (bus.o_time_sec !== 6'd62) begin
            n_bad++; $display("FAIL time_62 got %0d want 62", bus.o_time_sec);
        end
        repeat (30) tick();
        n_cmp++;
        if (bus.o_time_sec !== 6'd63) begin
            n_bad++; $display("FAIL time_sat got %0d want 63", bus.o_time_sec);
        end
        repeat (20) tick();
        n_cmp++;
        if ({bus.o_state, bus.o_time_sec} !== {3'd4, 6'd63}) begin
            n_bad++; $display("FAIL time_sat_hold got %h want %h", {bus.o_state, bus.o_time_sec}, {3'd4, 6'd63});
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (dut_vec() !== RESET_VEC) begin
            n_bad++; $display("FAIL midplay_reset got %h want %h", dut_vec(), RESET_VEC);
        end
        rst_n = 1'b1; bus.i_init_finished = 1'b1;
        tick();
        n_cmp++;
        if ({bus.o_state, bus.o_play_stop, bus.o_time_sec} !== {3'd1, 1'b0, 6'd0}) begin
            n_bad++; $display("FAIL post_reset_idle got %h want %h", {bus.o_state, bus.o_play_stop, bus.o_time_sec}, {3'd1, 1'b0, 6'd0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bus.i_key_0         = ($urandom_range(0, 3) == 0);
            bus.i_key_1         = ($urandom_range(0, 3) == 0);
            bus.i_key_2         = ($urandom_range(0, 9) == 0);
            bus.i_rec_full      = ($urandom_range(0, 40) == 0);
            bus.i_play_done     = ($urandom_range(0, 40) == 0);
            bus.i_init_finished = ($urandom_range(0, 3) != 0);
            bus.i_mode          = 2'($urandom_range(0, 3));
            bus.i_speed         = 3'($urandom_range(0, 7));
            rst_n               = ($urandom_range(0, 299) != 0);
            tick();
            n_cmp++;
            if (dut_vec() !== m_vec()) begin
                n_bad++; $display("FAIL random_cyc%0d got %h want %h", i, dut_vec(), m_vec());
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bus.i_key_0 = 1'b0; bus.i_key_1 = 1'b0; bus.i_key_2 = 1'b0;
        bus.i_mode = 2'b00; bus.i_speed = 3'd1;
        bus.i_init_finished = 1'b0; bus.i_rec_full = 1'b0; bus.i_play_done = 1'b0;
        test_reset();
        test_record_timer();
        test_play_mode();
        test_play_stop();
        test_rec_full_stop();
        test_saturate_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
